// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment lookup,
// scan states and the nibble-to-pattern helper. Patterns are active-high.
package sevenseg_pkg;

    // Segments a..g in bits 0..6 for hex digits 0-F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // All segments and the decimal point dark
    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    // Full 8-bit pattern: decimal point in bit 7, segments below it
    function automatic logic [7:0] seg_decode(input logic [3:0] nibble, input logic dp);
        return {dp, SEG_HEX[nibble]};
    endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex-to-segment decoder with a blank input that darkens
// segments a..g while leaving the decimal point alone.
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    // Look up the digit, then mask the segments for a suppressed leading zero
    always_comb begin
        pattern = seg_decode(nibble, dp);
        if (blank) begin
            pattern[6:0] = 7'h00;
        end
    end

endmodule

// File: rtl/driver_sevenseg_scan_bus.sv
// Time-multiplexed driver for a bank of seven-segment digits on a shared
// segment bus. One digit is lit at a time, separated by a dark dead time,
// and the displayed data is captured once per frame so it never tears.
module driver_sevenseg_scan_bus
    import sevenseg_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int ON_TICKS       = 4,
    parameter int DEAD_TICKS     = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    parameter bit LZ_SUPPRESS    = 1'b1
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dots,
    output logic [7:0]            seg_bus,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    if (DIGITS < 1 || ON_TICKS < 1) begin : g_bad_params
        $error("driver_sevenseg_scan_bus: DIGITS and ON_TICKS must both be >= 1");
    end

    localparam int MAX_TICKS = (ON_TICKS > DEAD_TICKS) ? ON_TICKS : DEAD_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = (DEAD_TICKS > 0) ? CNT_W'(DEAD_TICKS - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic                  en_meta;
    logic                  en_s;
    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;
    logic [4*DIGITS-1:0]   snap_data;
    logic [DIGITS-1:0]     snap_dots;
    logic [7:0]            seg_q;
    logic [DIGITS-1:0]     sel_q;

    logic [3:0]            nibble;
    logic                  dp;
    logic                  lz_blank;
    logic [7:0]            pattern;
    logic                  blank_done;
    logic                  show_done;

    // Two-flop synchroniser for the asynchronous enable
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments let both flops sample the old values on the same edge; blocking would collapse the synchroniser into one flop.
        if (reset) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= en;
            en_s    <= en_meta;
        end
    end

    // Select the current digit from the snapshot and decide on leading-zero blanking
    always_comb begin
        // NOTE: every output of this block gets a value before any condition, so no latch can be inferred.
        nibble     = 4'(snap_data >> {idx, 2'b00});
        dp         = 1'(snap_dots >> idx);
        lz_blank   = LZ_SUPPRESS && (idx != '0) && ((snap_data >> {idx, 2'b00}) == '0);
        blank_done = (DEAD_TICKS == 0) || (tick && (cnt == DEAD_LAST));
        show_done  = tick && (cnt == ON_LAST);
    end

    sevenseg_hex_decoder u_decoder (
        .nibble  (nibble),
        .dp      (dp),
        .blank   (lz_blank),
        .pattern (pattern)
    );

    // Scan FSM with snapshot, counters and registered active-high outputs
    always_ff @(posedge aclk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            snap_data  <= '0;
            snap_dots  <= '0;
            seg_q      <= SEG_OFF;
            sel_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A falling enable darkens the outputs immediately, not after IDLE is reached
            if (en_s && state == SHOW) begin
                seg_q <= pattern;
                sel_q <= DIGITS'(1) << idx;
            end else begin
                seg_q <= SEG_OFF;
                sel_q <= '0;
            end

            if (!en_s) begin
                state <= IDLE;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        snap_data <= data;
                        snap_dots <= dots;
                        idx       <= '0;
                        cnt       <= '0;
                        state     <= BLANK;
                    end
                    BLANK: begin
                        if (blank_done) begin
                            cnt   <= '0;
                            state <= SHOW;
                        end else if (tick) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    SHOW: begin
                        if (show_done) begin
                            cnt   <= '0;
                            state <= BLANK;
                            if (idx == IDX_LAST) begin
                                idx        <= '0;
                                frame_done <= 1'b1;
                                snap_data  <= data;
                                snap_dots  <= dots;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (tick) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Board polarity is applied after the registers
    assign seg_bus   = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign digit_sel = sel_q ^ {DIGITS{SEL_ACTIVE_LOW}};

endmodule

// File: tb/tb_driver_sevenseg_scan_bus.sv
// Directed bench for the seven-segment scan driver: a table of display
// values checked frame by frame, plus hand sequences for tearing, enable
// drop/restore and reset colliding with a terminal tick.
module tb_driver_sevenseg_scan_bus;

    logic       aclk  = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       en    = 1'b1;
    logic [7:0] data  = 8'h3A;
    logic [1:0] dots  = 2'b01;
    logic [7:0] seg_bus;
    logic [1:0] digit_sel;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_ph = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] dots;
        logic [7:0] seg0;
        logic [7:0] seg1;
    } vec_t;

    vec_t vecs [8];

    logic [7:0] s0, s1;
    int         n0, n1, noff, nfd, cnt, nlit;
    bit         bad, to, fd_seen;

    driver_sevenseg_scan_bus #(
        .DIGITS         (2),
        .ON_TICKS       (2),
        .DEAD_TICKS     (1),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b0),
        .LZ_SUPPRESS    (1'b1)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .tick       (tick),
        .en         (en),
        .data       (data),
        .dots       (dots),
        .seg_bus    (seg_bus),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #25 aclk = ~aclk;

    // One-cycle tick every fourth clock, changed just after the rising edge
    initial begin
        forever begin
            @(posedge aclk);
            #2;
            tick_ph = (tick_ph == 3) ? 0 : tick_ph + 1;
            tick    = (tick_ph == 3);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fd(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (frame_done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_sel(input logic [1:0] want, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (digit_sel == want) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Observe one complete frame, ending on the sample that carries frame_done
    task automatic capture_frame(output logic [7:0] c0, output logic [7:0] c1,
                                 output int k0, output int k1, output int koff,
                                 output int kfd, output bit kbad, output bit timed_out);
        bit seen1;
        c0 = 8'h00; c1 = 8'h00;
        k0 = 0; k1 = 0; koff = 0; kfd = 0;
        kbad = 1'b0; timed_out = 1'b1; seen1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (frame_done) kfd++;
            case (digit_sel)
                2'b00: begin
                    koff++;
                    if (seg_bus !== 8'hFF) kbad = 1'b1;
                end
                2'b01: begin
                    if (k0 == 0) c0 = seg_bus;
                    else if (seg_bus !== c0) kbad = 1'b1;
                    if (seen1) kbad = 1'b1;
                    k0++;
                end
                2'b10: begin
                    if (k1 == 0) c1 = seg_bus;
                    else if (seg_bus !== c1) kbad = 1'b1;
                    seen1 = 1'b1;
                    k1++;
                end
                default: kbad = 1'b1;
            endcase
            if (frame_done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'h3A, 2'b01, 8'h08, 8'hB0};
        vecs[1] = '{8'h3A, 2'b10, 8'h88, 8'h30};
        vecs[2] = '{8'h05, 2'b00, 8'h92, 8'hFF};
        vecs[3] = '{8'h00, 2'b00, 8'hC0, 8'hFF};
        vecs[4] = '{8'h00, 2'b10, 8'hC0, 8'h7F};
        vecs[5] = '{8'hF0, 2'b11, 8'h40, 8'h0E};
        vecs[6] = '{8'h8E, 2'b00, 8'h86, 8'h80};
        vecs[7] = '{8'h10, 2'b00, 8'hC0, 8'hF9};

        // Reset for one cycle with en high, then two cycles after release
        @(negedge aclk);
        check("reset_outputs", {seg_bus, 6'b0, digit_sel, 7'b0, frame_done}, {8'hFF, 6'b0, 2'b00, 7'b0, 1'b0});
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("post_reset_outputs", {seg_bus, 6'b0, digit_sel, 7'b0, frame_done}, {8'hFF, 6'b0, 2'b00, 7'b0, 1'b0});
        end

        // Table: new value is snapshotted at the next frame end, checked over the following frame
        for (int v = 0; v < 8; v++) begin
            data = vecs[v].data;
            dots = vecs[v].dots;
            wait_fd(to);
            check("vec_frame_timeout", to, 0);
            capture_frame(s0, s1, n0, n1, noff, nfd, bad, to);
            check("vec_capture_timeout", to, 0);
            check("vec_digit0_seg", s0, vecs[v].seg0);
            check("vec_digit1_seg", s1, vecs[v].seg1);
            check("vec_digit0_cycles", n0, 8);
            check("vec_digit1_cycles", n1, 8);
            check("vec_blank_cycles", noff, 8);
            check("vec_frame_done_count", nfd, 1);
            check("vec_frame_consistent", bad, 0);
        end

        // Data change while digit0 is lit must not reach digit1 this frame
        data = 8'h3A;
        dots = 2'b01;
        wait_fd(to);
        check("tear_setup_timeout", to, 0);
        wait_sel(2'b01, to);
        check("tear_digit0_timeout", to, 0);
        data = 8'h51;
        dots = 2'b00;
        s1 = 8'h00;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (digit_sel == 2'b10) s1 = seg_bus;
            if (frame_done) begin
                to = 1'b0;
                break;
            end
        end
        check("tear_frame_timeout", to, 0);
        check("tear_digit1_old_value", s1, 8'hB0);
        capture_frame(s0, s1, n0, n1, noff, nfd, bad, to);
        check("tear_next_digit0", s0, 8'hF9);
        check("tear_next_digit1", s1, 8'h92);

        // Drop enable while digit0 is lit
        wait_sel(2'b01, to);
        check("endrop_wait_timeout", to, 0);
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            cnt++;
            if (digit_sel == 2'b00 && seg_bus == 8'hFF) break;
        end
        check("endrop_off_within_3", (cnt <= 3), 1);
        fd_seen = 1'b0;
        nlit = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge aclk);
            if (frame_done) fd_seen = 1'b1;
            if (digit_sel != 2'b00 || seg_bus != 8'hFF) nlit++;
        end
        check("endrop_no_frame_done", fd_seen, 0);
        check("endrop_stays_dark", nlit, 0);

        // Re-enable: first lit digit is digit0 after the sync and one dead tick
        en = 1'b1;
        cnt = 0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            cnt++;
            if (frame_done) fd_seen = 1'b1;
            if (digit_sel != 2'b00) begin
                to = 1'b0;
                break;
            end
        end
        check("reenable_timeout", to, 0);
        check("reenable_first_digit", digit_sel, 2'b01);
        check("reenable_first_seg", seg_bus, 8'hF9);
        check("reenable_latency_in_range", (cnt >= 5 && cnt <= 8), 1);
        check("reenable_no_early_frame_done", fd_seen, 0);

        // Reset lands on the terminal tick of digit1
        wait_sel(2'b10, to);
        check("rst_tick_wait_timeout", to, 0);
        cnt = 0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (digit_sel == 2'b10 && tick) cnt++;
            if (cnt == 2) begin
                to = 1'b0;
                break;
            end
            @(negedge aclk);
        end
        check("rst_tick_align_timeout", to, 0);
        reset = 1'b1;
        @(negedge aclk);
        check("rst_tick_seg", seg_bus, 8'hFF);
        check("rst_tick_sel", digit_sel, 2'b00);
        check("rst_tick_frame_done", frame_done, 0);
        reset = 1'b0;
        fd_seen = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (frame_done) fd_seen = 1'b1;
            if (digit_sel != 2'b00) begin
                to = 1'b0;
                break;
            end
        end
        check("rst_tick_restart_timeout", to, 0);
        check("rst_tick_restart_digit0", digit_sel, 2'b01);
        check("rst_tick_no_frame_done", fd_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
